zoom_scan_controller: RTL and testbench

- Sequencer that sits directly upstream and downstream of the pixel-replication stage in the 2x zoom path.
- Sweeps every output coordinate of the 320x240 zoomed frame in raster order and drives X_OUT_COORD/Y_OUT_COORD into the replication stage.
- Captures the returned PIXEL value after the source-ROM read latency and writes it into the output frame buffer at the linear address Y*OUT_WIDTH+X.
- Runs one frame per START pulse, with a PAUSE throttle and BUSY/DONE status.

---
 rtl/zoom_scan_controller.sv | 233 +++++++++++++++++++++++
 tb/tb_zoom_scan_controller.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zoom_scan_controller.sv
// ---------------------------------------------------------------------------
// zoom_scan_controller
//
// Sequencer for the 2x zoom path. It sweeps every output coordinate of the
// zoomed frame in raster order, presents it to the pixel-replication stage,
// and writes the pixel that comes back (RD_LATENCY cycles later) into the
// output frame buffer at address Y*OUT_WIDTH+X. One frame is scanned per
// START pulse. PAUSE throttles coordinate issue, and BUSY/DONE report status.
//
// Optional feature (macro ZOOM_FRAME_CHECKSUM_EN): adds a 16-bit CHECKSUM
// output. It is the running sum of the frame's write data, modulo 2^16.
//
// Ports:
//   CLK          system clock; all logic is on the rising edge
//   RST_N        synchronous, active-low reset
//   START        one-cycle frame request; only honoured in IDLE
//   PAUSE        while high, no new coordinate is issued
//   X_OUT_COORD  output column to the replication stage (0..OUT_WIDTH-1)
//   Y_OUT_COORD  output line to the replication stage (0..OUT_HEIGHT-1)
//   PIXEL_IN     pixel returned by the replication stage
//   WR_EN        frame-buffer write strobe (registered)
//   WR_ADDR      frame-buffer write address (registered)
//   WR_DATA      frame-buffer write data (registered)
//   BUSY         high while scanning or draining in-flight reads
//   DONE         one-cycle pulse after the last write of a frame
//   CHECKSUM     (ZOOM_FRAME_CHECKSUM_EN only) frame write-data checksum
// ---------------------------------------------------------------------------
module zoom_scan_controller #(
    parameter int OUT_WIDTH  = 320,
    parameter int OUT_HEIGHT = 240,
    parameter int RD_LATENCY = 1,
    parameter int WR_ADDR_W  = 17
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 START,
    input  logic                 PAUSE,
    output logic [8:0]           X_OUT_COORD,
    output logic [7:0]           Y_OUT_COORD,
    input  logic [7:0]           PIXEL_IN,
    output logic                 WR_EN,
    output logic [WR_ADDR_W-1:0] WR_ADDR,
    output logic [7:0]           WR_DATA,
    output logic                 BUSY,
    output logic                 DONE
`ifdef ZOOM_FRAME_CHECKSUM_EN
    ,
    output logic [15:0]          CHECKSUM
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DRAIN,
        ST_FINISH
    } state_t;

    localparam logic [8:0]           X_LAST    = 9'(OUT_WIDTH - 1);
    localparam logic [7:0]           Y_LAST    = 8'(OUT_HEIGHT - 1);
    localparam logic [WR_ADDR_W-1:0] LINE_STEP = WR_ADDR_W'(OUT_WIDTH);

    state_t                 state_reg;
    logic [8:0]             x_reg;
    logic [7:0]             y_reg;
    logic [WR_ADDR_W-1:0]   line_base_reg;   // y_reg * OUT_WIDTH, accumulated
    logic                   busy_reg;
    logic                   done_reg;

    logic                   issue;
    logic [WR_ADDR_W-1:0]   issue_addr;
    logic [RD_LATENCY-1:0]  pipe_vld;
    logic                   tail_vld;
    logic [WR_ADDR_W-1:0]   tail_addr;

    logic                   wr_en_reg;
    logic [WR_ADDR_W-1:0]   wr_addr_reg;
    logic [7:0]             wr_data_reg;

    // A coordinate is consumed by the source ROM on every unpaused SCAN edge.
    assign issue      = (state_reg == ST_SCAN) && !PAUSE;
    assign issue_addr = line_base_reg + WR_ADDR_W'(x_reg);

    // -----------------------------------------------------------------------
    // Issue pipeline: valid bit and write address travel alongside the ROM
    // read so the address lines up with the returning pixel.
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < RD_LATENCY; gi++) begin : g_stage
            logic                 vld_reg;
            logic [WR_ADDR_W-1:0] addr_reg;

            if (gi == 0) begin : g_head
                always_ff @(posedge CLK) begin
                    if (!RST_N) begin
                        vld_reg  <= 1'b0;
                        addr_reg <= '0;
                    end else begin
                        vld_reg  <= issue;
                        addr_reg <= issue_addr;
                    end
                end
            end else begin : g_body
                always_ff @(posedge CLK) begin
                    if (!RST_N) begin
                        vld_reg  <= 1'b0;
                        addr_reg <= '0;
                    end else begin
                        vld_reg  <= g_stage[gi-1].vld_reg;
                        addr_reg <= g_stage[gi-1].addr_reg;
                    end
                end
            end

            assign pipe_vld[gi] = vld_reg;
        end
    endgenerate

    assign tail_vld  = g_stage[RD_LATENCY-1].vld_reg;
    assign tail_addr = g_stage[RD_LATENCY-1].addr_reg;

    // -----------------------------------------------------------------------
    // Control FSM with coordinate counters and registered status outputs.
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_reg     <= ST_IDLE;
            x_reg         <= '0;
            y_reg         <= '0;
            line_base_reg <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    done_reg <= 1'b0;
                    if (START) begin
                        state_reg     <= ST_SCAN;
                        x_reg         <= '0;
                        y_reg         <= '0;
                        line_base_reg <= '0;
                        busy_reg      <= 1'b1;
                    end
                end

                ST_SCAN: begin
                    if (!PAUSE) begin
                        if (x_reg == X_LAST) begin
                            if (y_reg == Y_LAST) begin
                                // Last coordinate issued: counters hold so
                                // the coordinate outputs stay at the final
                                // pixel until the next START.
                                state_reg <= ST_DRAIN;
                            end else begin
                                x_reg         <= '0;
                                y_reg         <= y_reg + 8'd1;
                                line_base_reg <= line_base_reg + LINE_STEP;
                            end
                        end else begin
                            x_reg <= x_reg + 9'd1;
                        end
                    end
                end

                ST_DRAIN: begin
                    // Nothing enters the pipeline here, so once it is empty
                    // the final write has already been performed.
                    if (!(|pipe_vld)) begin
                        state_reg <= ST_FINISH;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end
                end

                ST_FINISH: begin
                    state_reg <= ST_IDLE;
                    done_reg  <= 1'b0;
                end

                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Write port: the pixel on PIXEL_IN belongs to the pipeline tail entry.
    // Address and data hold between writes.
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wr_en_reg   <= 1'b0;
            wr_addr_reg <= '0;
            wr_data_reg <= '0;
        end else begin
            wr_en_reg <= tail_vld;
            if (tail_vld) begin
                wr_addr_reg <= tail_addr;
                wr_data_reg <= PIXEL_IN;
            end
        end
    end

`ifdef ZOOM_FRAME_CHECKSUM_EN
    logic [15:0] checksum_reg;

    // Accumulates the strobed write data, so the sum includes the final write
    // by the DONE cycle and then holds until the next accepted START.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            checksum_reg <= '0;
        end else if ((state_reg == ST_IDLE) && START) begin
            checksum_reg <= '0;
        end else if (wr_en_reg) begin
            checksum_reg <= checksum_reg + 16'(wr_data_reg);
        end
    end

    assign CHECKSUM = checksum_reg;
`endif

    assign X_OUT_COORD = x_reg;
    assign Y_OUT_COORD = y_reg;
    assign WR_EN       = wr_en_reg;
    assign WR_ADDR     = wr_addr_reg;
    assign WR_DATA     = wr_data_reg;
    assign BUSY        = busy_reg;
    assign DONE        = done_reg;

endmodule

// File: tb/tb_zoom_scan_controller.sv
// ---------------------------------------------------------------------------
// Testbench for zoom_scan_controller.
// A reduced frame geometry keeps the run short. The replication stage is
// modelled as a latency-RD_LATENCY lookup of a random source image at
// (X/2, Y/2). Starting a frame pushes the full expected write list into a
// scoreboard queue. A monitor pops and compares on every WR_EN and checks
// DONE/BUSY timing.
// ---------------------------------------------------------------------------
module tb_zoom_scan_controller;

    localparam int W   = 32;
    localparam int H   = 12;
    localparam int LAT = 1;
    localparam int AW  = 17;
    localparam int N   = W * H;
    localparam int SW  = W / 2;
    localparam int SN  = SW * (H / 2);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          pause = 1'b0;
    logic [8:0]    x_coord;
    logic [7:0]    y_coord;
    logic [7:0]    pixel_in;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          busy;
    logic          done_sig;
`ifdef ZOOM_FRAME_CHECKSUM_EN
    logic [15:0]   checksum;
`endif

    zoom_scan_controller #(
        .OUT_WIDTH (W),
        .OUT_HEIGHT(H),
        .RD_LATENCY(LAT),
        .WR_ADDR_W (AW)
    ) dut (
        .CLK        (clk),
        .RST_N      (rst_n),
        .START      (start),
        .PAUSE      (pause),
        .X_OUT_COORD(x_coord),
        .Y_OUT_COORD(y_coord),
        .PIXEL_IN   (pixel_in),
        .WR_EN      (wr_en),
        .WR_ADDR    (wr_addr),
        .WR_DATA    (wr_data),
        .BUSY       (busy),
        .DONE       (done_sig)
`ifdef ZOOM_FRAME_CHECKSUM_EN
        ,
        .CHECKSUM   (checksum)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- replication-stage / source ROM model ----------------
    logic [7:0] src_rom [SN];
    logic [7:0] pix_dly [LAT];

    function automatic int src_index(int x, int y);
        return (y / 2) * SW + (x / 2);
    endfunction

    always @(posedge clk) begin
        pix_dly[0] <= src_rom[src_index(int'(x_coord), int'(y_coord)) % SN];
        for (int i = 1; i < LAT; i++) pix_dly[i] <= pix_dly[i-1];
    end
    assign pixel_in = pix_dly[LAT-1];

    // ---------------- shared bookkeeping ----------------
    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;
    int  done_cnt = 0;
    int  busy_cnt = 0;
    int  frame_writes = 0;
    int  last_wr_cyc = 0;
    int  first_exp_cyc = 0;
    bit  first_pending = 0;
    bit  chk_busy = 0;
    int  prev_addr = -1;
    int  model_sum = 0;
    int  got_data [N];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (wr_en) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write_addr", int'(wr_addr), -1);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", int'(wr_addr), e.addr);
                    check("wr_data", int'(wr_data), e.data);
                    $display("write addr=%0d data=%0d cyc=%0d", wr_addr, wr_data, cyc);
                end
                if (first_pending) begin
                    check("first_write_cycle", cyc, first_exp_cyc);
                    first_pending = 0;
                end
                if (prev_addr == W - 1)
                    check("line_wrap_addr", int'(wr_addr), W);
                prev_addr = int'(wr_addr);
                if (int'(wr_addr) < N) got_data[wr_addr] = int'(wr_data);
                last_wr_cyc = cyc;
                frame_writes++;
            end
            if (busy) busy_cnt++;
            if (done_sig) begin
                done_cnt++;
                $display("done cyc=%0d writes=%0d busy_cycles=%0d", cyc, frame_writes, busy_cnt);
                check("done_queue_left", exp_q.size(), 0);
                check("done_writes", frame_writes, N);
                check("done_after_last_write", cyc - last_wr_cyc, 1);
                check("busy_in_done", int'(busy), 0);
                if (chk_busy) check("busy_cycles", busy_cnt, N + LAT + 1);
`ifdef ZOOM_FRAME_CHECKSUM_EN
                check("checksum_at_done", int'(checksum), model_sum % 65536);
`endif
                busy_cnt = 0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic randomize_rom();
        for (int i = 0; i < SN; i++) src_rom[i] = 8'($urandom);
    endtask

    // Issue START from IDLE and queue the full expected write list.
    task automatic start_frame(bit busy_exact);
        int x;
        int y;
        model_sum = 0;
        for (int a = 0; a < N; a++) begin
            x = a % W;
            y = a / W;
            exp_q.push_back('{addr: a, data: int'(src_rom[src_index(x, y)])});
            model_sum += int'(src_rom[src_index(x, y)]);
            got_data[a] = -1;
        end
        first_exp_cyc = cyc + 2 + LAT;
        first_pending = 1;
        chk_busy      = busy_exact;
        busy_cnt      = 0;
        frame_writes  = 0;
        prev_addr     = -1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("coord_x_after_start", int'(x_coord), 0);
        check("coord_y_after_start", int'(y_coord), 0);
`ifdef ZOOM_FRAME_CHECKSUM_EN
        check("checksum_cleared", int'(checksum), 0);
`endif
    endtask

    task automatic wait_done(string name, int budget, bit rand_pause);
        int d0;
        int n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < budget) begin
            pause = rand_pause ? ($urandom_range(0, 2) == 0) : 1'b0;
            tick();
            n++;
        end
        pause = 1'b0;
        check(name, done_cnt - d0, 1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        int base;
        int k;
        int d0;
        bit did;

        randomize_rom();

        // Reset then idle
        repeat (3) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_wr_en", int'(wr_en), 0);
            check("idle_busy", int'(busy), 0);
            check("idle_done", int'(done_sig), 0);
            check("idle_x", int'(x_coord), 0);
            check("idle_y", int'(y_coord), 0);
        end

        // Frame 1: unpaused, line-wrap coordinate check, pixel spot checks
        start_frame(1'b1);
        n = 0;
        while (!(x_coord == 9'(W - 1) && y_coord == 8'd0) && n < 200) begin
            tick();
            n++;
        end
        check("reach_x_last", int'(x_coord), W - 1);
        tick();
        check("wrap_x", int'(x_coord), 0);
        check("wrap_y", int'(y_coord), 1);
        wait_done("frame1_done", 4 * N, 1'b0);
        check("pix_w_plus_1", got_data[W + 1], int'(src_rom[0]));
        check("pix_w_plus_2", got_data[W + 2], int'(src_rom[1]));
        check("pix_last", got_data[N - 1], int'(src_rom[SN - 1]));
        repeat (3) tick();

        // Frame 2: random pause plus a directed 5-cycle pause at (10,2)
        randomize_rom();
        start_frame(1'b0);
        d0  = done_cnt;
        did = 0;
        n   = 0;
        while (done_cnt == d0 && n < 8 * N) begin
            if (!did && x_coord == 9'd10 && y_coord == 8'd2) begin
                pause = 1'b1;
                base  = 0;
                for (int i = 0; i < 5; i++) begin
                    tick();
                    check("pause_hold_x", int'(x_coord), 10);
                    check("pause_hold_y", int'(y_coord), 2);
                    if (i == 0) base = frame_writes;
                end
                check("pause_inflight_le_lat", int'((frame_writes - base) <= LAT), 1);
                pause = 1'b0;
                did   = 1;
            end else begin
                pause = ($urandom_range(0, 3) == 0);
                tick();
            end
            n++;
        end
        pause = 1'b0;
        check("frame2_done", done_cnt - d0, 1);
        check("directed_pause_hit", int'(did), 1);
        repeat (3) tick();

        // Frame 3: reset in the middle of the frame
        randomize_rom();
        start_frame(1'b0);
        k = int'($urandom_range(50, N - 50));
        n = 0;
        while (frame_writes < k && n < 4 * N) begin
            tick();
            n++;
        end
        check("reach_abort_point", int'(frame_writes >= k), 1);
        d0 = done_cnt;
        rst_n = 1'b0;
        tick();
        exp_q.delete();
        first_pending = 0;
        prev_addr = -1;
        check("abort_wr_en", int'(wr_en), 0);
        check("abort_busy", int'(busy), 0);
        tick();
        rst_n = 1'b1;
        busy_cnt = 0;
        repeat (20) tick();
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_idle_busy", int'(busy), 0);

        // Frame 4: restart from address 0 with a START pulsed during SCAN
        randomize_rom();
        d0 = done_cnt;
        start_frame(1'b1);
        repeat ($urandom_range(20, 100)) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("frame4_done", 4 * N, 1'b0);
        repeat (N / 2) tick();
        check("frame4_single_done", done_cnt - d0, 1);
        check("frame4_idle_busy", int'(busy), 0);
        check("final_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
